finder_pattern_scanner: RTL and testbench

// - Producer of the horz_patterns/vert_patterns masks consumed by cross_patterns.
// - Reads the binarised frame from BRAM: first row-major, then column-major.
// - Flags every row and column that contains a 1:1:3:1:1 dark/light/dark/light/dark run sequence.
// - Sits between the binarisation frame buffer and cross_patterns.

---
 rtl/finder_pattern_scanner_pkg.sv | 22 ++
 rtl/finder_pattern_scanner_if.sv | 23 ++
 rtl/finder_pattern_scanner_run_ratio_checker.sv | 56 +++++
 rtl/finder_pattern_scanner.sv | 107 ++++++++++
 tb/tb_finder_pattern_scanner.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/finder_pattern_scanner_pkg.sv
// finder_pattern_scanner_pkg: frame constants, scanner states, read sideband and ratio helper
package finder_pattern_scanner_pkg;
  localparam int IMG_W = 480;
  localparam int IMG_H = 480;
  localparam int COORD_W = 9;
  localparam logic [15:0] RATIO_UNIT_LO = 16'd1;
  localparam logic [15:0] RATIO_UNIT_HI = 16'd3;
  localparam logic [15:0] RATIO_CTR_LO = 16'd5;
  localparam logic [15:0] RATIO_CTR_HI = 16'd7;
  localparam logic [15:0] RATIO_SCALE = 16'd14;
  typedef enum logic [2:0] {IDLE, H_SCAN, H_DRAIN, V_SCAN, V_DRAIN, DONE} scan_state_e;
  typedef struct packed {
    logic v;
    logic ph;
    logic eol;
    logic [COORD_W-1:0] line;
  } read_meta_t;
  function automatic logic in_band(input logic [15:0] r14, input logic [15:0] t,
                                   input logic [15:0] lo, input logic [15:0] hi);
    return (r14 >= t * lo) && (r14 <= t * hi);
  endfunction
endpackage

// File: rtl/finder_pattern_scanner_if.sv
// finder_pattern_scanner_if: start/frame-buffer/mask bundle between scanner and its environment
interface finder_pattern_scanner_if import finder_pattern_scanner_pkg::*; #(
  parameter int WIDTH = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 18
) ();
  logic start_scan;
  logic [ADDR_W-1:0] pixel_addr;
  logic pixel_data;
  logic [HEIGHT-1:0] horz_patterns;
  logic [WIDTH-1:0] vert_patterns;
  logic busy;
  logic patterns_valid;
  logic pattern_error;
  modport master (
    input start_scan, pixel_data,
    output pixel_addr, horz_patterns, vert_patterns, busy, patterns_valid, pattern_error
  );
  modport slave (
    output start_scan, pixel_data,
    input pixel_addr, horz_patterns, vert_patterns, busy, patterns_valid, pattern_error
  );
endinterface

// File: rtl/finder_pattern_scanner_run_ratio_checker.sv
// finder_pattern_scanner_run_ratio_checker: per-line run tracker with registered 1:1:3:1:1 match
module finder_pattern_scanner_run_ratio_checker import finder_pattern_scanner_pkg::*; #(
  parameter int RUN_W = 9
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pix_i,
  input  logic valid_i,
  input  logic eol_i,
  output logic match_o
);
  localparam logic [RUN_W-1:0] RMAX = '1;
  localparam logic [RUN_W-1:0] ONE = RUN_W'(1);
  logic [4:0][RUN_W-1:0] runs_q, runs_d, w1, win;
  logic [RUN_W-1:0] len_q, len_d, cur_len;
  logic [2:0] cnt_q, cnt_d, c1, c2;
  logic col_q, col_d, cur_col, chg, dark, pass, match_q;
  logic [11:0] t;
  // At end of line a colour change can complete two runs at once: the old run, then the 1-px new one
  always_comb begin
    chg = (len_q != '0) && (pix_i != col_q);
    w1 = chg ? {len_q, runs_q[4:1]} : runs_q;
    c1 = (chg && cnt_q != 3'd5) ? cnt_q + 3'd1 : cnt_q;
    cur_col = (len_q == '0 || chg) ? pix_i : col_q;
    cur_len = (len_q == '0 || chg) ? ONE : (len_q == RMAX ? RMAX : len_q + ONE);
    win = eol_i ? {cur_len, w1[4:1]} : w1;
    c2 = (eol_i && c1 != 3'd5) ? c1 + 3'd1 : c1;
    dark = eol_i ? cur_col : (chg & col_q);
    t = 12'(win[0]) + 12'(win[1]) + 12'(win[2]) + 12'(win[3]) + 12'(win[4]);
    pass = 1'b1;
    for (int i = 0; i < 5; i++)
      pass = pass & (win[i] != RMAX) & ((i == 2)
        ? in_band(16'(win[i]) * RATIO_SCALE, 16'(t), RATIO_CTR_LO, RATIO_CTR_HI)
        : in_band(16'(win[i]) * RATIO_SCALE, 16'(t), RATIO_UNIT_LO, RATIO_UNIT_HI));
    runs_d = !valid_i ? runs_q : (eol_i ? '0 : w1);
    cnt_d = !valid_i ? cnt_q : (eol_i ? 3'd0 : c1);
    len_d = !valid_i ? len_q : (eol_i ? '0 : cur_len);
    col_d = !valid_i ? col_q : cur_col;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      runs_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      col_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      runs_q <= runs_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      col_q <= col_d;
      match_q <= valid_i & dark & (c2 == 3'd5) & pass;
    end
  end
  assign match_o = match_q;
endmodule

// File: rtl/finder_pattern_scanner.sv
// finder_pattern_scanner: row-major then column-major frame sweep producing finder-run line masks
module finder_pattern_scanner import finder_pattern_scanner_pkg::*; #(
  parameter int WIDTH = IMG_W,
  parameter int HEIGHT = IMG_H,
  parameter int ADDR_W = 18,
  parameter int RUN_W = 9,
  parameter int READ_LATENCY = 2
) (
  input logic clk_in,
  input logic rst_in,
  finder_pattern_scanner_if.master bus
);
  scan_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COORD_W-1:0] pos_q, pos_d, line_q, line_d, hit_line_q;
  logic [HEIGHT-1:0] hmask_q;
  logic [WIDTH-1:0] vmask_q;
  logic err_q, valid_q, hit_ph_q, match, h, last_pos, last_line, drained;
  read_meta_t meta_q [READ_LATENCY];
  read_meta_t cur_meta;
  // pos counts along the line during scans and doubles as the drain counter
  always_comb begin
    h = state_q == H_SCAN;
    last_pos = pos_q == COORD_W'(h ? WIDTH - 1 : HEIGHT - 1);
    last_line = line_q == COORD_W'(h ? HEIGHT - 1 : WIDTH - 1);
    drained = pos_q == COORD_W'(READ_LATENCY + 1);
    cur_meta.v = h | (state_q == V_SCAN);
    cur_meta.ph = h;
    cur_meta.eol = last_pos;
    cur_meta.line = line_q;
    state_d = state_q;
    addr_d = addr_q;
    pos_d = pos_q + COORD_W'(1);
    line_d = line_q;
    case (state_q)
      IDLE: begin
        pos_d = '0;
        line_d = '0;
        addr_d = '0;
        state_d = bus.start_scan ? H_SCAN : IDLE;
      end
      H_SCAN, V_SCAN: begin
        pos_d = last_pos ? '0 : pos_q + COORD_W'(1);
        line_d = last_pos ? line_q + COORD_W'(1) : line_q;
        addr_d = h ? addr_q + ADDR_W'(1)
                   : (last_pos ? ADDR_W'(line_q) + ADDR_W'(1) : addr_q + ADDR_W'(WIDTH));
        if (last_pos && last_line) begin
          state_d = h ? H_DRAIN : V_DRAIN;
          pos_d = '0;
          line_d = '0;
          addr_d = '0;
        end
      end
      H_DRAIN, V_DRAIN: if (drained) begin
        state_d = (state_q == H_DRAIN) ? V_SCAN : DONE;
        pos_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q <= '0;
      pos_q <= '0;
      line_q <= '0;
      hmask_q <= '0;
      vmask_q <= '0;
      err_q <= 1'b0;
      valid_q <= 1'b0;
      hit_line_q <= '0;
      hit_ph_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) meta_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pos_q <= pos_d;
      line_q <= line_d;
      meta_q[0] <= cur_meta;
      for (int i = 1; i < READ_LATENCY; i++) meta_q[i] <= meta_q[i-1];
      hit_line_q <= meta_q[READ_LATENCY-1].line;
      hit_ph_q <= meta_q[READ_LATENCY-1].ph;
      valid_q <= state_q == DONE;
      if (state_q == DONE) err_q <= (hmask_q == '0) || (vmask_q == '0);
      if (state_q == IDLE && bus.start_scan) begin
        hmask_q <= '0;
        vmask_q <= '0;
        err_q <= 1'b0;
      end else if (match && hit_ph_q) hmask_q <= hmask_q | (HEIGHT'(1) << hit_line_q);
      else if (match) vmask_q <= vmask_q | (WIDTH'(1) << hit_line_q);
    end
  end
  finder_pattern_scanner_run_ratio_checker #(.RUN_W(RUN_W)) u_chk (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .pix_i  (bus.pixel_data),
    .valid_i(meta_q[READ_LATENCY-1].v),
    .eol_i  (meta_q[READ_LATENCY-1].eol),
    .match_o(match)
  );
  assign bus.pixel_addr = addr_q;
  assign bus.horz_patterns = hmask_q;
  assign bus.vert_patterns = vmask_q;
  assign bus.busy = state_q != IDLE;
  assign bus.patterns_valid = valid_q;
  assign bus.pattern_error = err_q;
endmodule

// File: tb/tb_finder_pattern_scanner.sv
// tb_finder_pattern_scanner: directed scans of a 32x32 frame against a 2-cycle BRAM model
module tb_finder_pattern_scanner;
  localparam int W = 32, H = 32, AW = 10, RL = 2, N = W * H;
  localparam int LAT = 2 * (N + RL + 2) + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic frame [N];
  logic d1, d2;
  int total = 0, bad = 0, nvalid = 0, lat, n0;
  logic [H-1:0] fh_exp;
  logic [W-1:0] fv_exp;
  finder_pattern_scanner_if #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) bus ();
  finder_pattern_scanner #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RUN_W(9), .READ_LATENCY(RL)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    d1 <= frame[bus.pixel_addr];
    d2 <= d1;
    if (bus.patterns_valid) nvalid <= nvalid + 1;
  end
  assign bus.pixel_data = d2;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_frame();
    foreach (frame[i]) frame[i] = 1'b0;
  endtask
  // dark a, light b, dark c, light d, dark e starting at (x, y)
  task automatic runs5(input int y, input int x, input int a, input int b, input int c, input int d, input int e);
    int len [5];
    int p;
    len = '{a, b, c, d, e};
    p = x;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < len[k]; j++) begin
        frame[y * W + p] = (k % 2 == 0);
        p++;
      end
  endtask
  task automatic paint_finder(input int x0, input int y0);
    for (int dy = 0; dy < 21; dy++)
      for (int dx = 0; dx < 21; dx++)
        frame[(y0 + dy) * W + x0 + dx] = (dx / 3 == 0 || dx / 3 == 6 || dy / 3 == 0 || dy / 3 == 6) ||
          (dx / 3 >= 2 && dx / 3 <= 4 && dy / 3 >= 2 && dy / 3 <= 4);
  endtask
  // called at a negedge; returns the cycle count from start sampling to patterns_valid, or -1
  task automatic scan(input int pulse_at, output int l);
    bus.start_scan = 1'b1;
    @(negedge clk);
    bus.start_scan = 1'b0;
    l = -1;
    for (int k = 1; k <= 3 * N + 100; k++) begin
      @(negedge clk);
      if (k == pulse_at) bus.start_scan = 1'b1;
      if (k == pulse_at + 1) begin
        bus.start_scan = 1'b0;
        chk("busy_mid_h_scan", bus.busy, 1);
      end
      if (bus.patterns_valid) begin
        l = k;
        break;
      end
    end
  endtask
  initial begin
    bus.start_scan = 1'b0;
    clear_frame();
    fh_exp = '0;
    fv_exp = '0;
    for (int i = 14; i <= 22; i++) fh_exp[i] = 1'b1;
    for (int i = 11; i <= 19; i++) fv_exp[i] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.patterns_valid, 0);
    chk("rst_error", bus.pattern_error, 0);
    chk("rst_horz", bus.horz_patterns, 0);
    chk("rst_vert", bus.vert_patterns, 0);
    chk("rst_addr", bus.pixel_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    scan(-5, lat);
    chk("zero_latency", lat, LAT);
    chk("zero_horz", bus.horz_patterns, 0);
    chk("zero_vert", bus.vert_patterns, 0);
    chk("zero_error", bus.pattern_error, 1);
    chk("zero_busy_at_valid", bus.busy, 0);
    @(negedge clk);
    chk("valid_one_cycle", bus.patterns_valid, 0);
    chk("zero_nvalid", nvalid, 1);
    paint_finder(5, 8);
    n0 = nvalid;
    scan(100, lat);
    chk("finder_latency", lat, LAT);
    chk("finder_horz", bus.horz_patterns, fh_exp);
    chk("finder_vert", bus.vert_patterns, fv_exp);
    chk("finder_error", bus.pattern_error, 0);
    repeat (50) @(negedge clk);
    chk("finder_single_valid", nvalid, n0 + 1);
    chk("idle_horz_stable", bus.horz_patterns, fh_exp);
    chk("idle_vert_stable", bus.vert_patterns, fv_exp);
    chk("idle_busy", bus.busy, 0);
    clear_frame();
    runs5(3, 4, 2, 4, 9, 3, 3);
    runs5(6, 4, 1, 3, 9, 3, 3);
    runs5(9, 4, 3, 3, 6, 3, 3);
    scan(-5, lat);
    chk("ratio_latency", lat, LAT);
    chk("ratio_row3_set", bus.horz_patterns[3], 1);
    chk("ratio_row6_clear", bus.horz_patterns[6], 0);
    chk("ratio_row9_clear", bus.horz_patterns[9], 0);
    chk("ratio_horz", bus.horz_patterns, 64'h8);
    chk("ratio_vert", bus.vert_patterns, 0);
    chk("ratio_error", bus.pattern_error, 1);
    clear_frame();
    runs5(10, W - 21, 3, 3, 9, 3, 3);
    runs5(11, 0, 3, 3, 9, 3, 3);
    scan(-5, lat);
    chk("edge_row10", bus.horz_patterns[10], 1);
    chk("edge_row11", bus.horz_patterns[11], 1);
    chk("edge_horz", bus.horz_patterns, 64'hC00);
    chk("edge_vert", bus.vert_patterns, 0);
    clear_frame();
    paint_finder(5, 8);
    bus.start_scan = 1'b1;
    @(negedge clk);
    bus.start_scan = 1'b0;
    repeat (N + RL + 2 + 40) @(negedge clk);
    chk("mid_v_busy", bus.busy, 1);
    chk("mid_v_horz", bus.horz_patterns, fh_exp);
    n0 = nvalid;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_horz", bus.horz_patterns, 0);
    chk("abort_vert", bus.vert_patterns, 0);
    chk("abort_valid", bus.patterns_valid, 0);
    repeat (N + 50) @(negedge clk);
    chk("abort_no_valid", nvalid, n0);
    scan(-5, lat);
    chk("rescan_latency", lat, LAT);
    chk("rescan_horz", bus.horz_patterns, fh_exp);
    chk("rescan_vert", bus.vert_patterns, fv_exp);
    chk("rescan_error", bus.pattern_error, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
